// File: rtl/apb_master_if.sv
// apb_master_if: bundles the command, response and APB completer signals of
// apb_master so that the master and its environment connect through one port.
//   ADDR_W / DATA_W  address and data widths; the byte-strobe width is DATA_W/8
//   master modport   the apb_master view: it receives commands and APB
//                    responses, and it drives the response and APB request.
//   slave modport    the environment view (command source, response sink and
//                    APB completer).
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Command channel
  logic                cmd_valid_in;
  logic                cmd_ready_out;
  logic                cmd_write_in;
  logic [ADDR_W-1:0]   cmd_addr_in;
  logic [DATA_W-1:0]   cmd_wdata_in;
  logic [DATA_W/8-1:0] cmd_strb_in;
  // Response channel
  logic                rsp_valid_out;
  logic                rsp_ready_in;
  logic [DATA_W-1:0]   rsp_rdata_out;
  logic                rsp_slverr_out;
  logic                rsp_timeout_out;
  // APB requester side
  logic [ADDR_W-1:0]   apb_addr_out;
  logic                apb_psel_out;
  logic                apb_penable_out;
  logic                apb_write_out;
  logic [DATA_W-1:0]   apb_wdata_out;
  logic [DATA_W/8-1:0] apb_strb_out;
  // APB completer response
  logic                apb_ready_in;
  logic [DATA_W-1:0]   apb_rdata_in;
  logic                apb_slverr_in;

  modport master (
    input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, cmd_strb_in,
    output cmd_ready_out,
    output rsp_valid_out, rsp_rdata_out, rsp_slverr_out, rsp_timeout_out,
    input  rsp_ready_in,
    output apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out,
    output apb_wdata_out, apb_strb_out,
    input  apb_ready_in, apb_rdata_in, apb_slverr_in
  );

  modport slave (
    output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, cmd_strb_in,
    input  cmd_ready_out,
    input  rsp_valid_out, rsp_rdata_out, rsp_slverr_out, rsp_timeout_out,
    output rsp_ready_in,
    input  apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out,
    input  apb_wdata_out, apb_strb_out,
    output apb_ready_in, apb_rdata_in, apb_slverr_in
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: turns one command at a time into an APB transfer and returns a
// response carrying the read data, the slave error and a timeout flag.
//   apb_clk_in  clock; all state changes on its rising edge
//   apb_rst_in  synchronous active-high reset
//   bus         apb_master_if.master: command in, response out, APB request out
//               and APB completer response in
// Parameters: APB_ADDR_WIDTH, APB_DATA_WIDTH (must match the interface
// instance) and TIMEOUT_CYCLES, the ACCESS wait limit (0 = wait forever).
// Timing: accept at edge 0, SETUP in cycle 1, ACCESS from cycle 2, and RESP in
// the cycle after the completer ready (or the timeout). IDLE follows RESP, so
// one transfer takes at least four cycles.
module apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          apb_clk_in,
  input  logic          apb_rst_in,
  apb_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The last wait count before the timeout fires. It is only used when
  // TIMEOUT_CYCLES is nonzero, so the wrap to all-ones for 0 is harmless.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TIMEOUT_ON = (TIMEOUT_CYCLES > 0);

  state_t                      state;
  logic [15:0]                 wait_cnt;

  // The command fields that are captured on acceptance. Reads carry zero
  // wdata and strb onto the bus.
  logic [APB_ADDR_WIDTH-1:0]   cmd_addr;
  logic [APB_DATA_WIDTH-1:0]   cmd_wdata;
  logic [APB_DATA_WIDTH/8-1:0] cmd_strb;
  logic                        timeout_hit;

  always_comb begin
    cmd_addr    = bus.cmd_addr_in;
    cmd_wdata   = bus.cmd_write_in ? bus.cmd_wdata_in : '0;
    cmd_strb    = bus.cmd_write_in ? bus.cmd_strb_in  : '0;
    timeout_hit = TIMEOUT_ON && (wait_cnt == WAIT_LAST);
  end

  // NOTE: every output is a flop that is written here with non-blocking
  // assignments. The outputs therefore change only on the clock edge, and the
  // order of the statements inside the block does not matter.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      bus.cmd_ready_out   <= 1'b0;
      bus.rsp_valid_out   <= 1'b0;
      bus.rsp_rdata_out   <= '0;
      bus.rsp_slverr_out  <= 1'b0;
      bus.rsp_timeout_out <= 1'b0;
      bus.apb_addr_out    <= '0;
      bus.apb_psel_out    <= 1'b0;
      bus.apb_penable_out <= 1'b0;
      bus.apb_write_out   <= 1'b0;
      bus.apb_wdata_out   <= '0;
      bus.apb_strb_out    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // cmd_ready_out rises one cycle after reset and then stays high
          // until a command is accepted.
          if (bus.cmd_valid_in && bus.cmd_ready_out) begin
            bus.cmd_ready_out   <= 1'b0;
            bus.apb_addr_out    <= cmd_addr;
            bus.apb_write_out   <= bus.cmd_write_in;
            bus.apb_wdata_out   <= cmd_wdata;
            bus.apb_strb_out    <= cmd_strb;
            bus.apb_psel_out    <= 1'b1;
            bus.apb_penable_out <= 1'b0;
            state               <= SETUP;
          end else begin
            bus.cmd_ready_out   <= 1'b1;
          end
        end

        SETUP: begin
          bus.apb_penable_out <= 1'b1;
          wait_cnt            <= '0;
          state               <= ACCESS;
        end

        ACCESS: begin
          // A completer ready wins over a timeout in the same cycle.
          if (bus.apb_ready_in) begin
            bus.apb_psel_out    <= 1'b0;
            bus.apb_penable_out <= 1'b0;
            bus.rsp_slverr_out  <= bus.apb_slverr_in;
            bus.rsp_rdata_out   <= bus.apb_write_out ? '0 : bus.apb_rdata_in;
            bus.rsp_timeout_out <= 1'b0;
            bus.rsp_valid_out   <= 1'b1;
            state               <= RESP;
          end else if (timeout_hit) begin
            bus.apb_psel_out    <= 1'b0;
            bus.apb_penable_out <= 1'b0;
            bus.rsp_slverr_out  <= 1'b1;
            bus.rsp_rdata_out   <= '0;
            bus.rsp_timeout_out <= 1'b1;
            bus.rsp_valid_out   <= 1'b1;
            state               <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        RESP: begin
          // cmd_ready_out rises only when the response is consumed. A new
          // command can therefore be accepted on the next edge at the
          // earliest, and not on the consuming edge.
          if (bus.rsp_ready_in) begin
            bus.rsp_valid_out <= 1'b0;
            bus.cmd_ready_out <= 1'b1;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
